wb_trace_capture: RTL and testbench
===================================

Name: wb_trace_capture

Overview:
- Passive observer on the pipelined CPU's commit side. Captures every GRF write (W stage) and DM store (M stage) as a trace record and buffers it in a FWFT FIFO.
- Records drain to a debug consumer over a valid/ready port, which replaces per-cycle $display checking in the test fixture.
- Sits beside the mips top; it never stalls the pipeline. On overflow it drops records and counts the loss.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- FILTER_ZERO, 1, when 1, GRF writes with grf_addr==0 are not recorded.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- grf_we  in  1  W-stage register write strobe.
- grf_pc  in  32  PC of the writing instruction.
- grf_addr  in  5  destination register.
- grf_data  in  32  value written.
- dm_we  in  1  M-stage store strobe.
- dm_pc  in  32  PC of the store.
- dm_addr  in  32  byte address.
- dm_data  in  32  stored word.
- out_valid  out  1  head record present.
- out_ready  in  1  consumer accepts head.
- out_kind  out  1  0=GRF record, 1=DM record.
- out_pc  out  32  record PC.
- out_addr  out  32  GRF: zero-extended reg number; DM: byte address.
- out_data  out  32  record data.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on the first dropped record.
- drop_cnt  out  16  dropped records, saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0, async):
  - Read/write pointers and level go to 0; out_valid=0.
  - overflow=0, drop_cnt=0.
  - out_kind/out_pc/out_addr/out_data go to 0.
  - Deassertion is sampled on clk; the first event is captured on the first rising edge with reset==1.
- Event qualification:
  - GRF event = grf_we & !(FILTER_ZERO & grf_addr==0).
  - DM event = dm_we.
  - A GRF write filtered out by FILTER_ZERO is neither recorded nor counted as a drop.
- Ordering:
  - When both events occur in one cycle, the GRF record is enqueued first, because the W-stage instruction is older. The DM record goes into the next slot.
  - Records leave in strict enqueue order.
- Capacity:
  - Free slots = DEPTH - level, evaluated before any pop that happens in the same cycle. A pop does not make room for a same-cycle push.
  - 2 events, free>=2: both enqueued.
  - 2 events, free==1: GRF enqueued; DM dropped.
  - 2 events, free==0: both dropped.
  - 1 event, free==0: event dropped.
  - Each dropped record increments drop_cnt by 1 (saturating) and sets overflow. A cycle that drops 2 records adds 2.
- Output handshake:
  - FWFT: out_valid = (level!=0). out_* always shows the head entry.
  - Pop occurs when out_valid & out_ready at the clock edge.
  - While out_valid=1 and out_ready=0, out_* stays stable.
  - Push latency: a record captured at edge N is visible at out_* after edge N (zero bubbles when the FIFO was empty).
- Level update: level_next = level + pushes(0..2) - pop(0..1). Never exceeds DEPTH and never underflows.
- Pointers: wrap modulo DEPTH. A 2-record push writes slots wptr and wptr+1 (mod DEPTH).
- out_valid=0 with out_ready=1: no pop; no state change.
- Reset mid-drain: all buffered records are discarded; out_valid falls asynchronously.

Test Plan:
- Reset held low, then single GRF write pc=0x3000, $1<=0x12 -> one cycle later out_valid=1, kind=0, pc=0x3000, addr=1, data=0x12, level=1; pop with out_ready -> level=0, out_valid=0.
- Same cycle: GRF pc=0x3004 $2<=5 and DM pc=0x3008 [0x10]<=7 -> two records in order GRF then DM; level=2.
- FILTER_ZERO=1, GRF write to $0 data=0xFF -> no record, level=0, drop_cnt=0, overflow=0.
- DEPTH=16, out_ready=0, 16 GRF writes -> level=16. Then a dual event -> both dropped, drop_cnt=2, overflow=1. The head is still the first record.
- level=15, dual event with a same-cycle pop -> GRF kept, DM dropped, level stays 15, drop_cnt+=1.
- 8 records buffered with out_ready=0, pulse reset low mid-cycle -> out_valid=0 immediately and level=0. After release, a new event appears as the head.

Source files
------------

// File: rtl/wb_trace_capture.sv
// wb_trace_capture
// Passive observer on the CPU commit side. Each qualified GRF write (W stage)
// and DM store (M stage) becomes a trace record in a first-word-fall-through
// FIFO that a debug consumer drains over a valid/ready port. The block never
// back-pressures the pipeline: records that find no room are dropped and
// counted.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   grf_*      W-stage register write strobe, pc, destination, data
//   dm_*       M-stage store strobe, pc, byte address, data
//   out_valid  head record present
//   out_ready  consumer accepts head
//   out_kind   0 = GRF record, 1 = DM record
//   out_pc     record pc
//   out_addr   GRF: zero-extended register number; DM: byte address
//   out_data   record data
//   level      current occupancy
//   overflow   sticky, set by the first dropped record
//   drop_cnt   dropped record count, saturating
module wb_trace_capture #(
    parameter int DEPTH       = 16,
    parameter bit FILTER_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [31:0]              grf_pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_data,
    input  logic                     dm_we,
    input  logic [31:0]              dm_pc,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 97;   // {kind, pc, addr, data}

    logic [RW-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW-1:0] rptr_reg, rptr_next;
    logic [LW-1:0] level_reg, level_next;
    logic          overflow_reg, overflow_next;
    logic [15:0]   drop_cnt_reg, drop_cnt_next;

    logic          grf_ev;
    logic [1:0]    n_events;
    logic [1:0]    n_push;
    logic [1:0]    n_drop;
    logic [LW-1:0] free_slots;
    logic          pop;
    logic [16:0]   drop_sum;
    logic [RW-1:0] rec_grf, rec_dm, rec0, rec1;
    logic [RW-1:0] head_rec;
    logic [AW-1:0] wptr_plus1;

    assign rec_grf    = {1'b0, grf_pc, 27'd0, grf_addr, grf_data};
    assign rec_dm     = {1'b1, dm_pc, dm_addr, dm_data};
    assign wptr_plus1 = wptr_reg + AW'(1);

    always_comb begin
        grf_ev   = grf_we && !(FILTER_ZERO && (grf_addr == 5'd0));
        n_events = {1'b0, grf_ev} + {1'b0, dm_we};

        // The older W-stage write always takes the first slot.
        rec0 = grf_ev ? rec_grf : rec_dm;
        rec1 = rec_dm;

        // Room is judged before any same-cycle pop, so a full FIFO drops
        // even while the consumer is taking the head.
        free_slots = LW'(DEPTH) - level_reg;
        if (free_slots >= LW'(n_events)) begin
            n_push = n_events;
        end else if (free_slots != '0) begin
            n_push = 2'd1;
        end else begin
            n_push = 2'd0;
        end
        n_drop = n_events - n_push;

        pop = (level_reg != '0) && out_ready;

        level_next = level_reg + LW'(n_push) - LW'(pop);
        wptr_next  = wptr_reg + AW'(n_push);
        rptr_next  = rptr_reg + AW'(pop);

        drop_sum      = {1'b0, drop_cnt_reg} + 17'(n_drop);
        drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_next = overflow_reg || (n_drop != 2'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            level_reg    <= level_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem[wptr_reg] <= rec0;
        end
        if (n_push == 2'd2) begin
            mem[wptr_plus1] <= rec1;
        end
    end

    // Head is gated so the record fields read zero whenever nothing is held,
    // including immediately on reset assertion.
    assign head_rec  = (level_reg != '0) ? mem[rptr_reg] : '0;

    assign out_valid = (level_reg != '0);
    assign out_kind  = head_rec[96];
    assign out_pc    = head_rec[95:64];
    assign out_addr  = head_rec[63:32];
    assign out_data  = head_rec[31:0];
    assign level     = level_reg;
    assign overflow  = overflow_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_wb_trace_capture.sv
module tb_wb_trace_capture;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          grf_we = 1'b0;
    logic [31:0]   grf_pc = '0;
    logic [4:0]    grf_addr = '0;
    logic [31:0]   grf_data = '0;
    logic          dm_we = 1'b0;
    logic [31:0]   dm_pc = '0;
    logic [31:0]   dm_addr = '0;
    logic [31:0]   dm_data = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic          out_kind;
    logic [31:0]   out_pc;
    logic [31:0]   out_addr;
    logic [31:0]   out_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    // Reference model: a queue of expected records plus loss bookkeeping.
    rec_t mq[$];
    int   m_drop = 0;
    bit   m_ovf  = 1'b0;

    wb_trace_capture #(.DEPTH(DEPTH), .FILTER_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // Applies one clock edge worth of rules to the model using current inputs.
    task automatic model_edge();
        rec_t ev[$];
        int   free;
        free = DEPTH - mq.size();
        if (grf_we && grf_addr != 5'd0)
            ev.push_back('{1'b0, grf_pc, {27'd0, grf_addr}, grf_data});
        if (dm_we)
            ev.push_back('{1'b1, dm_pc, dm_addr, dm_data});
        if (mq.size() != 0 && out_ready)
            void'(mq.pop_front());
        foreach (ev[i]) begin
            if (free > 0) begin
                mq.push_back(ev[i]);
                free--;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        grf_we = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        out_ready = 1'b0;
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, level, overflow, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state valid=%0b level=%0d ovf=%0b drops=%0d want all 0",
                     out_valid, level, overflow, drop_cnt);
        end
        checks++;
        if ({out_kind, out_pc, out_addr, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_fields kind=%0b pc=%h addr=%h data=%h want 0",
                     out_kind, out_pc, out_addr, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_single_grf();
        grf_we = 1'b1; grf_pc = 32'h3000; grf_addr = 5'd1; grf_data = 32'h12;
        cycle();
        set_idle();
        checks++;
        if ({out_valid, out_kind, out_pc, out_addr, out_data} !== {1'b1, 1'b0, 32'h3000, 32'd1, 32'h12}) begin
            errors++;
            $display("FAIL single_head valid=%0b kind=%0b pc=%h addr=%h data=%h want 1 0 3000 1 12",
                     out_valid, out_kind, out_pc, out_addr, out_data);
        end
        checks++;
        if (level !== LW'(1)) begin
            errors++;
            $display("FAIL single_level got %0d want 1", level);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== LW'(0)) begin
            errors++;
            $display("FAIL single_pop valid=%0b level=%0d want 0 0", out_valid, level);
        end
        $display("test_single_grf done");
    endtask

    task automatic test_dual();
        grf_we = 1'b1; grf_pc = 32'h3004; grf_addr = 5'd2; grf_data = 32'd5;
        dm_we = 1'b1; dm_pc = 32'h3008; dm_addr = 32'h10; dm_data = 32'd7;
        cycle();
        set_idle();
        checks++;
        if (level !== LW'(2)) begin
            errors++;
            $display("FAIL dual_level got %0d want 2", level);
        end
        checks++;
        if ({out_kind, out_pc, out_addr, out_data} !== {1'b0, 32'h3004, 32'd2, 32'd5}) begin
            errors++;
            $display("FAIL dual_first kind=%0b pc=%h addr=%h data=%h want 0 3004 2 5",
                     out_kind, out_pc, out_addr, out_data);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if ({out_valid, out_kind, out_pc, out_addr, out_data} !== {1'b1, 1'b1, 32'h3008, 32'h10, 32'd7}) begin
            errors++;
            $display("FAIL dual_second valid=%0b kind=%0b pc=%h addr=%h data=%h want 1 1 3008 10 7",
                     out_valid, out_kind, out_pc, out_addr, out_data);
        end
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dual_empty valid=%0b want 0", out_valid);
        end
        $display("test_dual done");
    endtask

    task automatic test_filter_zero();
        grf_we = 1'b1; grf_pc = 32'h300C; grf_addr = 5'd0; grf_data = 32'hFF;
        cycle();
        set_idle();
        checks++;
        if ({out_valid, level, drop_cnt, overflow} !== '0) begin
            errors++;
            $display("FAIL filter_zero valid=%0b level=%0d drops=%0d ovf=%0b want all 0",
                     out_valid, level, drop_cnt, overflow);
        end
        $display("test_filter_zero done");
    endtask

    task automatic test_full_and_pop();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            grf_we = 1'b1; grf_pc = 32'h4000 + 32'(4 * i);
            grf_addr = 5'((i % 31) + 1); grf_data = 32'(i);
            cycle();
        end
        set_idle();
        checks++;
        if (level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL full_level got %0d want %0d", level, DEPTH);
        end
        grf_we = 1'b1; grf_pc = 32'h5000; grf_addr = 5'd3; grf_data = 32'hAA;
        dm_we = 1'b1; dm_pc = 32'h5004; dm_addr = 32'h20; dm_data = 32'hBB;
        cycle();
        set_idle();
        checks++;
        if (drop_cnt !== 16'd2 || overflow !== 1'b1 || level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL full_drop drops=%0d ovf=%0b level=%0d want 2 1 %0d",
                     drop_cnt, overflow, level, DEPTH);
        end
        checks++;
        if (out_pc !== 32'h4000 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL full_head pc=%h data=%h want 4000 0", out_pc, out_data);
        end
        // Pop once to reach 15, then a dual event alongside a pop.
        out_ready = 1'b1;
        cycle();
        grf_we = 1'b1; grf_pc = 32'h6000; grf_addr = 5'd4; grf_data = 32'hCC;
        dm_we = 1'b1; dm_pc = 32'h6004; dm_addr = 32'h30; dm_data = 32'hDD;
        cycle();
        set_idle();
        out_ready = 1'b0;
        checks++;
        if (level !== LW'(DEPTH - 1) || drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL l15_pop level=%0d drops=%0d want %0d 3", level, drop_cnt, DEPTH - 1);
        end
        checks++;
        if (out_pc !== 32'h4008) begin
            errors++;
            $display("FAIL l15_head pc=%h want 4008", out_pc);
        end
        // Drain and confirm strict order ends with the kept GRF record.
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            checks++;
            if (out_valid !== (mq.size() != 0) ||
                (mq.size() != 0 && {out_kind, out_pc, out_addr, out_data} !== mq[0])) begin
                errors++;
                $display("FAIL drain_%0d valid=%0b pc=%h data=%h want valid=%0b pc=%h data=%h",
                         i, out_valid, out_pc, out_data, mq.size() != 0,
                         (mq.size() != 0) ? mq[0].pc : 32'd0, (mq.size() != 0) ? mq[0].data : 32'd0);
            end
            cycle();
        end
        out_ready = 1'b0;
        $display("test_full_and_pop done");
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            grf_we = 1'b1; grf_pc = 32'h7000 + 32'(4 * i);
            grf_addr = 5'(i + 1); grf_data = 32'h100 + 32'(i);
            cycle();
        end
        set_idle();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== LW'(0)) begin
            errors++;
            $display("FAIL midreset_async valid=%0b level=%0d want 0 0", out_valid, level);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        grf_we = 1'b1; grf_pc = 32'h8000; grf_addr = 5'd9; grf_data = 32'h99;
        cycle();
        set_idle();
        checks++;
        if ({out_valid, out_pc, out_addr, out_data} !== {1'b1, 32'h8000, 32'd9, 32'h99} ||
            level !== LW'(1)) begin
            errors++;
            $display("FAIL midreset_new valid=%0b pc=%h addr=%h data=%h level=%0d want 1 8000 9 99 1",
                     out_valid, out_pc, out_addr, out_data, level);
        end
        $display("test_reset_mid_drain done");
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            grf_we    = ($urandom_range(0, 99) < 60);
            grf_pc    = $urandom;
            grf_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            grf_data  = $urandom;
            dm_we     = ($urandom_range(0, 99) < 50);
            dm_pc     = $urandom;
            dm_addr   = $urandom;
            dm_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < ((n < 200) ? 30 : 80));
            cycle();
            checks++;
            if (out_valid !== (mq.size() != 0) || level !== LW'(mq.size()) ||
                drop_cnt !== 16'(m_drop) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_state_%0d valid=%0b level=%0d drops=%0d ovf=%0b want %0b %0d %0d %0b",
                         n, out_valid, level, drop_cnt, overflow,
                         mq.size() != 0, mq.size(), m_drop, m_ovf);
            end
            if (mq.size() != 0) begin
                checks++;
                if ({out_kind, out_pc, out_addr, out_data} !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_head_%0d got %0b %h %h %h want %0b %h %h %h", n,
                             out_kind, out_pc, out_addr, out_data,
                             mq[0].kind, mq[0].pc, mq[0].addr, mq[0].data);
                end
            end
        end
        set_idle();
        out_ready = 1'b0;
        $display("test_random done drops=%0d", m_drop);
    endtask

    initial begin
        test_reset();
        test_single_grf();
        test_dual();
        test_filter_zero();
        test_full_and_pop();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
